// File: rtl/fb_rect_fill_if.sv
// Command and pixel-bus bundle for the rectangle fill engine.
// master: command source / frame-buffer memory side; slave: fill engine.
// Ports: cmd_* request/accept, px_* memory access with px_ready, busy/done/pix_count status.
// cmd_xor exists only when FB_FILL_XOR_EN is defined.
interface fb_rect_fill_if #(
  parameter int COUNT_W = 17
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [7:0]         cmd_col;
  logic [7:0]         cmd_row;
  logic [8:0]         cmd_width;
  logic [8:0]         cmd_height;
  logic [23:0]        cmd_colour;
`ifdef FB_FILL_XOR_EN
  logic               cmd_xor;
`endif
  logic [7:0]         px_col_address;
  logic [7:0]         px_row_address;
  logic [23:0]        px_write_data;
  logic               px_request;
  logic               px_write;
  logic [23:0]        px_read_data;
  logic               px_ready;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] pix_count;

  modport master (
`ifdef FB_FILL_XOR_EN
    output cmd_xor,
`endif
    output cmd_valid, cmd_col, cmd_row, cmd_width, cmd_height, cmd_colour,
    input  cmd_ready,
    input  px_col_address, px_row_address, px_write_data, px_request, px_write,
    output px_read_data, px_ready,
    input  busy, done, pix_count
  );

  modport slave (
`ifdef FB_FILL_XOR_EN
    input  cmd_xor,
`endif
    input  cmd_valid, cmd_col, cmd_row, cmd_width, cmd_height, cmd_colour,
    output cmd_ready,
    output px_col_address, px_row_address, px_write_data, px_request, px_write,
    input  px_read_data, px_ready,
    output busy, done, pix_count
  );
endinterface

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: writes a colour over a WxH pixel block in raster order.
// Latency: one pixel per cycle when px_ready returns in the request cycle; done one cycle after the last write.
// Backpressure: px_ready low freezes address/data/request; commands are accepted only while idle.
// Ports: clk, reset (sync, active-high), bus (fb_rect_fill_if.slave: cmd_*, px_*, busy, done, pix_count).
// Optional feature macro FB_FILL_XOR_EN: adds cmd_xor and a read-modify-write (read, then write read^colour) per pixel.
module fb_rect_fill #(
  parameter int COUNT_W = 17
) (
  input  logic          clk,
  input  logic          reset,
  fb_rect_fill_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
`ifdef FB_FILL_XOR_EN
  localparam logic [1:0] ST_RD   = 2'd2;
`endif
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]         state;
  logic [7:0]         start_col;
  logic [7:0]         col_idx;
  logic [7:0]         row_idx;
  logic [7:0]         width_m1;
  logic [7:0]         height_m1;
  logic [7:0]         cur_col;
  logic [7:0]         cur_row;
  logic [23:0]        wr_data;
  logic               req;
  logic               wr;
  logic [COUNT_W-1:0] count;
`ifdef FB_FILL_XOR_EN
  logic [23:0]        colour;
  logic               xor_mode;
`else
  logic               unused_rd;
  assign unused_rd = ^bus.px_read_data;
`endif

  // Sizes are held as size-1 so a full 256 fits in 8 bits; anything with bit 8 set saturates.
  logic [7:0] w_m1;
  logic [7:0] h_m1;
  logic       zero_size;
  logic       last_col;
  logic       last_row;

  always_comb begin
    w_m1      = bus.cmd_width[8]  ? 8'hFF : (bus.cmd_width[7:0]  - 8'd1);
    h_m1      = bus.cmd_height[8] ? 8'hFF : (bus.cmd_height[7:0] - 8'd1);
    zero_size = (bus.cmd_width == 9'd0) || (bus.cmd_height == 9'd0);
    last_col  = (col_idx == width_m1);
    last_row  = (row_idx == height_m1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      start_col <= 8'd0;
      col_idx   <= 8'd0;
      row_idx   <= 8'd0;
      width_m1  <= 8'd0;
      height_m1 <= 8'd0;
      cur_col   <= 8'd0;
      cur_row   <= 8'd0;
      wr_data   <= 24'd0;
      req       <= 1'b0;
      wr        <= 1'b0;
      count     <= '0;
`ifdef FB_FILL_XOR_EN
      colour    <= 24'd0;
      xor_mode  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            start_col <= bus.cmd_col;
            cur_col   <= bus.cmd_col;
            cur_row   <= bus.cmd_row;
            width_m1  <= w_m1;
            height_m1 <= h_m1;
            col_idx   <= 8'd0;
            row_idx   <= 8'd0;
            wr_data   <= bus.cmd_colour;
            count     <= '0;
`ifdef FB_FILL_XOR_EN
            colour    <= bus.cmd_colour;
            xor_mode  <= bus.cmd_xor;
`endif
            if (zero_size) begin
              state <= ST_DONE;
              req   <= 1'b0;
              wr    <= 1'b0;
            end else begin
              req   <= 1'b1;
`ifdef FB_FILL_XOR_EN
              state <= bus.cmd_xor ? ST_RD : ST_WR;
              wr    <= ~bus.cmd_xor;
`else
              state <= ST_WR;
              wr    <= 1'b1;
`endif
            end
          end
        end
`ifdef FB_FILL_XOR_EN
        ST_RD: begin
          // Request stays high; only the write strobe and data change for the write phase.
          if (bus.px_ready) begin
            wr_data <= bus.px_read_data ^ colour;
            wr      <= 1'b1;
            state   <= ST_WR;
          end
        end
`endif
        ST_WR: begin
          if (bus.px_ready) begin
            count <= count + COUNT_W'(1);
            if (last_col && last_row) begin
              state <= ST_DONE;
              req   <= 1'b0;
              wr    <= 1'b0;
            end else begin
              // Addresses wrap modulo 256 naturally through 8-bit arithmetic.
              if (last_col) begin
                col_idx <= 8'd0;
                cur_col <= start_col;
                row_idx <= row_idx + 8'd1;
                cur_row <= cur_row + 8'd1;
              end else begin
                col_idx <= col_idx + 8'd1;
                cur_col <= cur_col + 8'd1;
              end
`ifdef FB_FILL_XOR_EN
              if (xor_mode) begin
                state <= ST_RD;
                wr    <= 1'b0;
              end
`endif
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          req   <= 1'b0;
          wr    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready      = (state == ST_IDLE);
  assign bus.busy           = (state != ST_IDLE);
  assign bus.done           = (state == ST_DONE);
  assign bus.px_col_address = cur_col;
  assign bus.px_row_address = cur_row;
  assign bus.px_write_data  = wr_data;
  assign bus.px_request     = req;
  assign bus.px_write       = wr;
  assign bus.pix_count      = count;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Bench for fb_rect_fill: directed commands, a pixel-list model of the rectangle and a frame-buffer array.
// Outputs are sampled on the falling edge; px_ready/px_read_data are driven there for the next rising edge.
module tb_fb_rect_fill;

  logic clk;
  logic reset;

  fb_rect_fill_if #(.COUNT_W(17)) bus ();

  fb_rect_fill #(.COUNT_W(17)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  row;
    logic [7:0]  col;
    logic [23:0] colour;
    bit          xr;
  } px_t;

  px_t         exp_q[$];
  int          exp_count;
  int          wr_seen;
  int          total;
  int          bad;
  int          stall_at;
  int          stall_len;
  int          rd_wait;
  int          wait_cnt;
  logic [23:0] mem [0:65535];
  logic [7:0]  prev_col;
  logic [7:0]  prev_row;
  logic [23:0] prev_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Model: the pixel list of a rectangle in raster order, addresses modulo 256.
  task automatic load_model(input logic [7:0] col, input logic [7:0] row, input int w, input int h,
                            input logic [23:0] colour, input bit xr);
    int we;
    int he;
    px_t e;
    we = (w > 256) ? 256 : w;
    he = (h > 256) ? 256 : h;
    exp_q.delete();
    for (int r = 0; r < he; r++) begin
      for (int c = 0; c < we; c++) begin
        e.row    = 8'((int'(row) + r) % 256);
        e.col    = 8'((int'(col) + c) % 256);
        e.colour = colour;
        e.xr     = xr;
        exp_q.push_back(e);
      end
    end
    exp_count = we * he;
    wr_seen   = 0;
  endtask

  // Memory/responder and per-cycle checker.
  always @(negedge clk) begin
    logic rdy;
    int   need;
    px_t  e;
    logic [23:0] want;
    if (reset) begin
      wait_cnt         = 0;
      bus.px_ready     = 1'b1;
      bus.px_read_data = 24'd0;
    end else begin
      chk("wr_without_req", {31'd0, bus.px_write & ~bus.px_request}, 32'd0);
      chk("done_with_req", {31'd0, bus.done & bus.px_request}, 32'd0);
`ifndef FB_FILL_XOR_EN
      chk("write_strobe", {31'd0, bus.px_write}, {31'd0, bus.px_request});
`endif
      rdy = 1'b1;
      if (bus.px_request) begin
        need = bus.px_write ? ((wr_seen == stall_at) ? stall_len : 0) : rd_wait;
        if (wait_cnt > 0) begin
          chk("stall_col", {24'd0, bus.px_col_address}, {24'd0, prev_col});
          chk("stall_row", {24'd0, bus.px_row_address}, {24'd0, prev_row});
          chk("stall_data", {8'd0, bus.px_write_data}, {8'd0, prev_data});
        end
        if (wait_cnt < need) begin
          rdy = 1'b0;
          wait_cnt++;
        end else begin
          wait_cnt = 0;
        end
        prev_col  = bus.px_col_address;
        prev_row  = bus.px_row_address;
        prev_data = bus.px_write_data;
        if (rdy && bus.px_write) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got row %0d col %0d, want no write",
                     bus.px_row_address, bus.px_col_address);
          end else begin
            e    = exp_q.pop_front();
            want = e.xr ? (mem[{e.row, e.col}] ^ e.colour) : e.colour;
            chk("wr_row", {24'd0, bus.px_row_address}, {24'd0, e.row});
            chk("wr_col", {24'd0, bus.px_col_address}, {24'd0, e.col});
            chk("wr_data", {8'd0, bus.px_write_data}, {8'd0, want});
          end
          mem[{bus.px_row_address, bus.px_col_address}] = bus.px_write_data;
          wr_seen++;
        end
        if (rdy && !bus.px_write)
          bus.px_read_data = mem[{bus.px_row_address, bus.px_col_address}];
      end else begin
        wait_cnt = 0;
      end
      bus.px_ready = rdy;
      if (bus.done) begin
        chk("done_pixels_left", exp_q.size(), 32'd0);
        chk("done_pix_count", {15'd0, bus.pix_count}, exp_count);
      end
    end
  end

  task automatic run_cmd(input logic [7:0] col, input logic [7:0] row, input logic [8:0] w,
                         input logic [8:0] h, input logic [23:0] colour, input bit junk,
                         input int exp_lat, input string nm);
    int lat;
    bit got;
    @(posedge clk); #1;
    bus.cmd_col    = col;
    bus.cmd_row    = row;
    bus.cmd_width  = w;
    bus.cmd_height = h;
    bus.cmd_colour = colour;
`ifdef FB_FILL_XOR_EN
    bus.cmd_xor    = (exp_q.size() > 0) ? exp_q[0].xr : 1'b0;
`endif
    bus.cmd_valid  = 1'b1;
    @(negedge clk);
    chk({nm, "_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk); #1;
    if (junk) begin
      // Offer a different command while busy; it must not disturb the fill.
      bus.cmd_col    = col + 8'd40;
      bus.cmd_row    = row + 8'd40;
      bus.cmd_colour = ~colour;
      bus.cmd_width  = 9'd7;
    end else begin
      bus.cmd_valid = 1'b0;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (bus.done) got = 1'b1;
    end
    bus.cmd_valid = 1'b0;
    chk({nm, "_latency"}, lat, exp_lat);
    @(negedge clk);
    chk({nm, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({nm, "_idle_after"}, {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    int n;
    int seen_done;
    total = 0;
    bad = 0;
    stall_at = -1;
    stall_len = 0;
    rd_wait = 0;
    wait_cnt = 0;
    wr_seen = 0;
    exp_count = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 24'd0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_col = 8'd0;
    bus.cmd_row = 8'd0;
    bus.cmd_width = 9'd0;
    bus.cmd_height = 9'd0;
    bus.cmd_colour = 24'd0;
`ifdef FB_FILL_XOR_EN
    bus.cmd_xor = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_req", {31'd0, bus.px_request}, 32'd0);
    chk("rst_count", {15'd0, bus.pix_count}, 32'd0);
    chk("rst_col", {24'd0, bus.px_col_address}, 32'd0);
    chk("rst_data", {8'd0, bus.px_write_data}, 32'd0);

    // 3x2 at (col 10, row 20): six back-to-back writes, done on the 7th cycle.
    load_model(8'd10, 8'd20, 3, 2, 24'hFF0000, 1'b0);
    chk("model_first_row", {24'd0, exp_q[0].row}, 32'd20);
    chk("model_first_col", {24'd0, exp_q[0].col}, 32'd10);
    chk("model_last_row", {24'd0, exp_q[5].row}, 32'd21);
    chk("model_last_col", {24'd0, exp_q[5].col}, 32'd12);
    run_cmd(8'd10, 8'd20, 9'd3, 9'd2, 24'hFF0000, 1'b0, 7, "basic");

    // Wrap across both edges.
    load_model(8'd254, 8'd255, 4, 2, 24'h123456, 1'b0);
    chk("model_wrap_size", exp_q.size(), 32'd8);
    chk("model_wrap_col", {24'd0, exp_q[2].col}, 32'd0);
    chk("model_wrap_row", {24'd0, exp_q[4].row}, 32'd0);
    chk("model_wrap_col4", {24'd0, exp_q[4].col}, 32'd254);
    run_cmd(8'd254, 8'd255, 9'd4, 9'd2, 24'h123456, 1'b0, 9, "wrap");

    // Empty rectangles complete immediately with no pixel traffic.
    load_model(8'd1, 8'd2, 0, 5, 24'h00AA00, 1'b0);
    run_cmd(8'd1, 8'd2, 9'd0, 9'd5, 24'h00AA00, 1'b0, 1, "zero_w");
    load_model(8'd1, 8'd2, 5, 0, 24'h00AA00, 1'b0);
    run_cmd(8'd1, 8'd2, 9'd5, 9'd0, 24'h00AA00, 1'b0, 1, "zero_h");

    // Three-cycle stall on the second pixel, with a competing command offered while busy.
    load_model(8'd3, 8'd4, 3, 1, 24'hABCDEF, 1'b0);
    stall_at = 1;
    stall_len = 3;
    run_cmd(8'd3, 8'd4, 9'd3, 9'd1, 24'hABCDEF, 1'b1, 7, "stall");
    stall_at = -1;
    stall_len = 0;

    // Oversized width saturates to 256 columns.
    load_model(8'd5, 8'd7, 300, 1, 24'h0F0F0F, 1'b0);
    run_cmd(8'd5, 8'd7, 9'd300, 9'd1, 24'h0F0F0F, 1'b0, 257, "saturate");

`ifdef FB_FILL_XOR_EN
    // Read-modify-write of one pixel, read data returned on the second read cycle.
    mem[16'h0000] = 24'h00FF00;
    load_model(8'd0, 8'd0, 1, 1, 24'hFFFFFF, 1'b1);
    rd_wait = 1;
    run_cmd(8'd0, 8'd0, 9'd1, 9'd1, 24'hFFFFFF, 1'b0, 4, "xor");
    rd_wait = 0;
    chk("xor_mem_value", {8'd0, mem[16'h0000]}, 32'hFF00FF);
`endif

    // Reset during a 16x16 fill: abort without a completion pulse.
    load_model(8'd100, 8'd100, 16, 16, 24'h55AA55, 1'b0);
    @(posedge clk); #1;
    bus.cmd_col = 8'd100;
    bus.cmd_row = 8'd100;
    bus.cmd_width = 9'd16;
    bus.cmd_height = 9'd16;
    bus.cmd_colour = 24'h55AA55;
`ifdef FB_FILL_XOR_EN
    bus.cmd_xor = 1'b0;
`endif
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    n = 0;
    while (wr_seen < 5 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("abort_reached_5", {31'd0, wr_seen >= 5}, 32'd1);
    reset = 1'b1;
    exp_q.delete();
    exp_count = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_req", {31'd0, bus.px_request}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_count", {15'd0, bus.pix_count}, 32'd0);
    chk("abort_row", {24'd0, bus.px_row_address}, 32'd0);
    seen_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    chk("abort_no_done", seen_done, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_rect_fill.md
FB_RECT_FILL -- requirements
Module: fb_rect_fill

Interface
REQ-001 Parameter: COUNT_W, default 17, width of pix_count (holds 0..65536).
REQ-002 clk  input  1  108 MHz pixel clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered; cmd_ready  output  1  engine idle, command accepted when both high.
REQ-005 cmd_col, cmd_row  input  8 each  top-left pixel of rectangle.
REQ-006 cmd_width, cmd_height  input  9 each  rectangle size, 0..256; values >256 saturate to 256.
REQ-007 cmd_colour  input  24  fill value; cmd_xor  input  1  XOR mode select (FB_FILL_XOR_EN only).
REQ-008 px_col_address, px_row_address  output  8 each; px_write_data  output  24; px_request  output  1; px_write  output  1.
REQ-009 px_read_data  input  24; px_ready  input  1  write done / read data valid.
REQ-010 busy  output  1; done  output  1  one-cycle pulse; pix_count  output  COUNT_W  pixels written by last/current command.

Function
REQ-011 States: IDLE, RD (XOR builds only), WR, DONE; cmd_ready = (state==IDLE).
REQ-012 IDLE: on cmd_valid, latch all cmd_* fields, clear pix_count, cur_col=cmd_col, cur_row=cmd_row; go WR (or RD if XOR active); width or height 0 -> go DONE, no px_request issued.
REQ-013 WR: px_request=1, px_write=1, address={cur_row,cur_col}, data=colour (or captured^colour); all held stable until px_ready sampled high.
REQ-014 px_ready high in WR: pix_count+1; advance raster order, column first; last column of row -> column back to start col, row+1; last pixel -> DONE.
REQ-015 Write throughput: one pixel per cycle when px_ready is returned in the request cycle; any cycle with px_ready low stalls without changing outputs.
REQ-016 RD: px_request=1, px_write=0, same address; on px_ready capture px_read_data, go WR next cycle; px_request remains high across the RD->WR transition.
REQ-017 Address arithmetic modulo 256: cur_col and cur_row wrap 255->0; rectangle crossing the edge wraps and is not clipped.
REQ-018 DONE: done=1 for exactly one cycle, px_request=0, then IDLE; cmd_ready high the cycle after done.
REQ-019 busy=1 in every state except IDLE.
REQ-020 px_request low in IDLE and DONE; px_write low whenever px_request low.
REQ-021 cmd_valid while busy is ignored; latched fields do not change mid-command.
REQ-022 px_ready asserted while px_request low is ignored.

Reset
REQ-023 reset high at clk edge -> state IDLE; px_request, px_write, busy and done are 0 that cycle onward; pix_count=0; cmd_ready=1 the cycle after reset.
REQ-024 Reset mid-command aborts with no completion pulse; pixels already written stay written.
REQ-025 Address and data registers reset to 0.

Configuration
REQ-026 Macro FB_FILL_XOR_EN defined: RD state present; cmd_xor=1 selects read-modify-write per pixel, written value = px_read_data ^ cmd_colour.
REQ-027 Macro FB_FILL_XOR_EN undefined: no RD state, no cmd_xor port, px_read_data unused, px_write always 1 when px_request high.

Verification
REQ-028 cmd col=10,row=20,w=3,h=2,colour=0xFF0000, px_ready tied to px_request -> writes (20,10),(20,11),(20,12),(21,10),(21,11),(21,12) on 6 consecutive cycles; done pulse; pix_count=6.
REQ-029 cmd col=254,row=255,w=4,h=2 -> columns 254,255,0,1 on row 255 then on row 0; pix_count=8.
REQ-030 w=0,h=5 -> no px_request; done one cycle after acceptance; pix_count=0.
REQ-031 px_ready held low 3 cycles on 2nd pixel -> address/data stable during stall; total latency increases by 3.
REQ-032 XOR build: memory model holds 0x00FF00 at (0,0), cmd w=1,h=1,colour=0xFFFFFF,cmd_xor=1, read ready 2 cycles later -> one read then write 0xFF00FF.
REQ-033 Reset asserted after 5 pixels of a 16x16 fill -> px_request 0 next cycle, no done, cmd_ready 1, pix_count 0.
